// File: rtl/ram_param.sv
// Single-port byte-write RAM that zero-fills itself after reset and offers an
// optional second read register stage.
module ram_param #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned OUT_REG = 0,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned NB     = WIDTH / 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN0,
    input  logic [NB-1:0]    WE0,
    input  logic [AW-1:0]    A0,
    input  logic [WIDTH-1:0] Di0,
    output logic [WIDTH-1:0] Do0,
    output logic             VALID0,
    output logic             READY
);

    typedef enum logic {StClear, StRun} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [NB-1:0]    wr_be;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd1_d, rd1_q;
    logic             vld1_d, vld1_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_be   = '0;
        wr_addr = ptr_q;
        wr_data = '0;
        rd1_d   = '0;
        vld1_d  = 1'b0;
        if (state_q == StClear) begin
            wr_be = '1;
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(DEPTH - 1)) begin
                state_d = StRun;
            end
        end else if (EN0) begin
            wr_be   = WE0;
            wr_addr = A0;
            wr_data = Di0;
            rd1_d   = mem_q[A0];
            vld1_d  = 1'b1;
        end
        // A reset edge must never disturb the array.
        if (RST) begin
            wr_be = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StClear;
            ptr_q   <= '0;
            rd1_q   <= '0;
            vld1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rd1_q   <= rd1_d;
            vld1_q  <= vld1_d;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [WIDTH-1:0] rd2_q;
        logic             vld2_q;

        always_ff @(posedge CLK) begin
            if (RST) begin
                rd2_q  <= '0;
                vld2_q <= 1'b0;
            end else begin
                rd2_q  <= rd1_q;
                vld2_q <= vld1_q;
            end
        end

        assign Do0    = rd2_q;
        assign VALID0 = vld2_q;
    end else begin : g_no_out_reg
        assign Do0    = rd1_q;
        assign VALID0 = vld1_q;
    end

    assign READY = (state_q == StRun);

endmodule

// File: tb/tb_ram_param.sv
// Drives one stimulus stream into a 1-cycle and a 2-cycle ram_param and checks
// both against a word-array model plus a few literal scenario values.
module tb_ram_param;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN0;
    logic [3:0]  WE0;
    logic [2:0]  A0;
    logic [31:0] Di0;
    logic [31:0] do_a, do_b;
    logic        vld_a, vld_b, rdy_a, rdy_b;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    always #5 CLK = ~CLK;

    ram_param #(.WIDTH(32), .DEPTH(8), .OUT_REG(0)) u_lat1 (
        .CLK(CLK), .RST(RST), .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0),
        .Do0(do_a), .VALID0(vld_a), .READY(rdy_a)
    );

    ram_param #(.WIDTH(32), .DEPTH(8), .OUT_REG(1)) u_lat2 (
        .CLK(CLK), .RST(RST), .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0),
        .Do0(do_b), .VALID0(vld_b), .READY(rdy_b)
    );

    // Model: cycles left in the clear sweep, the word array, and the read
    // results seen after one and two register stages.
    int          m_left = 8;
    logic [31:0] m_mem [8];
    logic [31:0] m_d1, m_d2;
    logic        m_v1, m_v2;

    always @(posedge CLK) begin
        if (RST) begin
            m_left = 8;
            m_d1 = '0; m_v1 = 1'b0;
            m_d2 = '0; m_v2 = 1'b0;
        end else begin
            m_d2 = m_d1;
            m_v2 = m_v1;
            if (m_left > 0) begin
                m_left = m_left - 1;
                m_d1 = '0;
                m_v1 = 1'b0;
                if (m_left == 0) begin
                    for (int i = 0; i < 8; i++) m_mem[i] = '0;
                end
            end else if (EN0) begin
                m_d1 = m_mem[A0];
                m_v1 = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (WE0[b]) m_mem[A0][8*b +: 8] = Di0[8*b +: 8];
                end
            end else begin
                m_d1 = '0;
                m_v1 = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("lat1_do", do_a, m_d1);
            check("lat1_valid", {31'b0, vld_a}, {31'b0, m_v1});
            check("lat1_ready", {31'b0, rdy_a}, {31'b0, m_left == 0});
            check("lat2_do", do_b, m_d2);
            check("lat2_valid", {31'b0, vld_b}, {31'b0, m_v2});
            check("lat2_ready", {31'b0, rdy_b}, {31'b0, m_left == 0});
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [3:0] w,
                       input logic [2:0] a, input logic [31:0] d);
        RST = r; EN0 = e; WE0 = w; A0 = a; Di0 = d;
        @(negedge CLK);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 4'h0, 3'd0, 32'h0);
        chk_en = 1'b1;
        cyc(1'b1, 1'b0, 4'h0, 3'd0, 32'h0);

        // Sweep with writes requested throughout; they must all be dropped.
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b1, 4'hF, 3'd3, $urandom);
            if (k == 1) check("sweep_ready_c1", {31'b0, rdy_a}, 32'd0);
            if (k == 7) check("sweep_ready_c7", {31'b0, rdy_a}, 32'd0);
            if (k == 8) check("sweep_ready_c8", {31'b0, rdy_a}, 32'd1);
        end
        cyc(1'b0, 1'b1, 4'h0, 3'd3, 32'h0);
        check("clear_lost_do", do_a, 32'h0);
        check("clear_lost_valid", {31'b0, vld_a}, 32'd1);

        // Byte-lane merge.
        cyc(1'b0, 1'b1, 4'hF, 3'd5, 32'hDEADBEEF);
        cyc(1'b0, 1'b1, 4'b0101, 3'd5, 32'h11223344);
        check("lane_first_rd", do_a, 32'hDEADBEEF);
        cyc(1'b0, 1'b1, 4'h0, 3'd5, 32'h0);
        check("lane_merge_do", do_a, 32'hDE22BE44);
        check("lane_merge_valid", {31'b0, vld_a}, 32'd1);

        // Read-first on a same-address write.
        cyc(1'b0, 1'b1, 4'hF, 3'd2, 32'hAAAA5555);
        cyc(1'b0, 1'b1, 4'hF, 3'd2, 32'h12345678);
        check("rdfirst_old", do_a, 32'hAAAA5555);
        cyc(1'b0, 1'b1, 4'h0, 3'd2, 32'h0);
        check("rdfirst_new", do_a, 32'h12345678);

        // Two-stage pipeline throughput.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'hF, 3'(i), 32'(i));
        cyc(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        cyc(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        cyc(1'b0, 1'b1, 4'h0, 3'd0, 32'h0);
        check("pipe_pre_valid", {31'b0, vld_b}, 32'd0);
        cyc(1'b0, 1'b1, 4'h0, 3'd1, 32'h0);
        check("pipe_t2_do", do_b, 32'd0);
        check("pipe_t2_valid", {31'b0, vld_b}, 32'd1);
        cyc(1'b0, 1'b1, 4'h0, 3'd2, 32'h0);
        check("pipe_t3_do", do_b, 32'd1);
        cyc(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        check("pipe_t4_do", do_b, 32'd2);
        check("pipe_t4_valid", {31'b0, vld_b}, 32'd1);
        cyc(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        check("pipe_idle_do", do_b, 32'd0);
        check("pipe_idle_valid", {31'b0, vld_b}, 32'd0);

        // Reset midway through a sweep restarts it over every word.
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 4'hF, 3'(i), 32'hC0DE0000 | 32'(i + 1));
        cyc(1'b1, 1'b0, 4'h0, 3'd0, 32'h0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        cyc(1'b1, 1'b0, 4'h0, 3'd0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
            if (k == 7) check("restart_ready_c7", {31'b0, rdy_a}, 32'd0);
            if (k == 8) check("restart_ready_c8", {31'b0, rdy_a}, 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 4'h0, 3'(i), 32'h0);
            check("restart_word_zero", do_a, 32'h0);
        end

        // Reset in RUN with a read still in the second stage.
        cyc(1'b0, 1'b1, 4'hF, 3'd6, 32'h600DF00D);
        cyc(1'b0, 1'b1, 4'hF, 3'd1, 32'h01010101);
        cyc(1'b0, 1'b1, 4'h0, 3'd6, 32'h0);
        cyc(1'b1, 1'b0, 4'h0, 3'd0, 32'h0);
        check("flush_valid", {31'b0, vld_b}, 32'd0);
        check("flush_do", do_b, 32'h0);
        check("flush_ready", {31'b0, rdy_b}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
            if (k == 7) check("flush_ready_c7", {31'b0, rdy_b}, 32'd0);
            if (k == 8) check("flush_ready_c8", {31'b0, rdy_b}, 32'd1);
        end
        cyc(1'b0, 1'b1, 4'h0, 3'd6, 32'h0);
        check("flush_word6", do_a, 32'h0);
        cyc(1'b0, 1'b1, 4'h0, 3'd1, 32'h0);
        check("flush_word1", do_a, 32'h0);

        // Randomised traffic with occasional resets, checked by the model.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), $urandom);
        end
        cyc(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        cyc(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits; legal values are multiples of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 8, number of words; legal values are powers of two, minimum 2.
REQ-003 SHALL have parameter OUT_REG, default 0, read pipeline select: 0 gives 1-cycle read latency, 1 gives 2-cycle read latency.
REQ-004 SHALL derive localparam AW = clog2(DEPTH) and localparam NB = WIDTH/8.
REQ-005 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port EN0  input  1  access enable for read and write.
REQ-008 SHALL have port WE0  input  NB  byte-lane write enables; bit i covers Di0[8i+7:8i].
REQ-009 SHALL have port A0  input  AW  word address.
REQ-010 SHALL have port Di0  input  WIDTH  write data.
REQ-011 SHALL have port Do0  output  WIDTH  registered read data.
REQ-012 SHALL have port VALID0  output  1  high in the cycle where Do0 carries a read result.
REQ-013 SHALL have port READY  output  1  high when the array accepts accesses; low during the clear sweep.

Function
REQ-014 SHALL implement a two-state FSM with states CLEAR and RUN.
REQ-015 In CLEAR, the block SHALL write all-zero to mem[ptr] each cycle and then increment ptr, which is AW bits wide.
REQ-016 SHALL transition CLEAR->RUN on the edge that writes ptr==DEPTH-1, so that READY rises exactly DEPTH cycles after the RST-deassert edge.
REQ-017 In CLEAR, the block SHALL ignore EN0, WE0, A0 and Di0: no user write occurs, the read stage captures 0, and the VALID pipeline captures 0.
REQ-018 In RUN with EN0=1, the read stage SHALL capture mem[A0] as it was before this edge (read-first); a same-address write is not visible until a later read.
REQ-019 In RUN with EN0=1, for each i with WE0[i]=1, byte lane i of mem[A0] SHALL take Di0 lane i; lanes with WE0[i]=0 SHALL remain unchanged.
REQ-020 In RUN with EN0=0, the read stage SHALL capture 0, no write SHALL occur, and the VALID stage SHALL capture 0.
REQ-021 The VALID pipeline SHALL capture (state==RUN && EN0) and SHALL have the same depth as the data path.
REQ-022 With OUT_REG=0, Do0 and VALID0 SHALL be the stage-1 registers, giving 1-cycle latency.
REQ-023 With OUT_REG=1, a second register stage SHALL copy stage 1 unconditionally, giving 2-cycle latency, with back-to-back reads at full throughput.
REQ-024 Reads and writes SHALL be accepted every cycle, with no stall and no backpressure.
REQ-025 The address space SHALL be exact (DEPTH is a power of two), so no out-of-range handling is required.

Reset
REQ-026 With RST=1 at an edge, the block SHALL set state=CLEAR, ptr=0, READY=0, all Do0/VALID0 pipeline registers to 0, and perform no array write on that edge.
REQ-027 While RST is held, those values SHALL hold; the sweep SHALL start on the first edge with RST=0.
REQ-028 RST asserted mid-sweep SHALL restart the sweep from ptr=0.
REQ-029 RST asserted in RUN SHALL discard all contents, re-clearing the full array, and SHALL flush in-flight reads (VALID0=0 on the next edge).
REQ-030 Array contents before the first completed sweep SHALL be don't-care; no output SHALL expose them.

Verification (WIDTH=32, DEPTH=8 unless noted)
REQ-031 Scenario: release RST, hold EN0=1, WE0=4'hF, A0=3 throughout -> READY=0 for cycles 1-8 and rises after edge 8; the writes issued during CLEAR are lost, and a read of A0=3 after READY returns 32'h0.
REQ-032 Scenario: in RUN, write A0=5, Di0=32'hDEADBEEF, WE0=4'hF; then write A0=5, Di0=32'h11223344, WE0=4'b0101; then read A0=5 -> Do0=32'hDE22BE44 with VALID0=1, one cycle after the read.
REQ-033 Scenario: mem[2]=32'hAAAA5555; one cycle with EN0=1, A0=2, WE0=4'hF, Di0=32'h12345678, then a read of A0=2 -> first Do0=32'hAAAA5555 (read-first), second Do0=32'h12345678.
REQ-034 Scenario: OUT_REG=1, reads of A0=0,1,2 on consecutive cycles with mem[n]=n -> Do0 = 0, 1, 2 on cycles t+2, t+3, t+4, with VALID0 high on exactly those cycles; EN0=0 afterwards -> Do0=0, VALID0=0.
REQ-035 Scenario: assert RST at sweep cycle 4 for one cycle -> READY rises 8 cycles after release, and all 8 words read 0.
REQ-036 Scenario: RST in RUN with a read in flight (OUT_REG=1) -> VALID0=0 and Do0=0 on the next edge, READY=0 for 8 cycles, then previously written words read 0.
